// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer owning HI/LO; counts out a fixed latency per operation.
// Optional MADD (md_op=7) support is enabled by defining MD_MADD_EN.
module md_sequencer #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        id_md_use,
    output logic        busy,
    output logic        done,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;
    localparam logic [3:0] OpMadd  = 4'd7;

    logic [0:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [63:0]     shadow_q, shadow_d;
    logic            madd_q, madd_d;
    logic            keep_q, keep_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;
    logic            done_q, done_d;

    logic is_mul, is_div, is_madd, is_multi;

    always_comb begin
        is_madd = 1'b0;
`ifdef MD_MADD_EN
        is_madd = (md_op == OpMadd);
`endif
        is_mul   = (md_op == OpMult) || (md_op == OpMultu) || is_madd;
        is_div   = (md_op == OpDiv) || (md_op == OpDivu);
        is_multi = is_mul || is_div;
    end

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;

    assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
    assign prod_u = {32'd0, src_a} * {32'd0, src_b};

    // Divisor of 1 for /0 (result discarded) and for MIN/-1, where a/1 is exactly the wanted
    // quotient 0x80000000 with remainder 0 and avoids the signed overflow case.
    logic               div_ovf;
    logic [31:0]        divisor_s, divisor_u;
    logic signed [31:0] quot_s, rem_s;
    logic [31:0]        quot_u, rem_u;

    assign div_ovf   = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
    assign divisor_s = ((src_b == 32'd0) || div_ovf) ? 32'd1 : src_b;
    assign divisor_u = (src_b == 32'd0) ? 32'd1 : src_b;
    assign quot_s    = $signed(src_a) / $signed(divisor_s);
    assign rem_s     = $signed(src_a) % $signed(divisor_s);
    assign quot_u    = src_a / divisor_u;
    assign rem_u     = src_a % divisor_u;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        madd_d   = madd_q;
        keep_d   = keep_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (is_multi) begin
                        state_d = StRun;
                        madd_d  = is_madd;
                        keep_d  = is_div && (src_b == 32'd0);
                        cnt_d   = is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                        case (md_op)
                            OpMultu: shadow_d = prod_u;
                            OpDiv:   shadow_d = {rem_s, quot_s};
                            OpDivu:  shadow_d = {rem_u, quot_u};
                            default: shadow_d = prod_s;
                        endcase
                    end else if (md_op == OpMthi) begin
                        hi_d = src_a;
                    end else if (md_op == OpMtlo) begin
                        lo_d = src_a;
                    end
                end
            end
            StRun: begin
                if (cnt_q <= CntW'(1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    // MADD accumulates onto HI/LO as they stand at commit.
                    if (madd_q) begin
                        {hi_d, lo_d} = {hi_q, lo_q} + shadow_q;
                    end else if (!keep_q) begin
                        {hi_d, lo_d} = shadow_q;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            shadow_q <= '0;
            madd_q   <= 1'b0;
            keep_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            madd_q   <= madd_d;
            keep_q   <= keep_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy      = (state_q == StRun);
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign stall_req = id_md_use & (busy | (start & is_multi));

endmodule
